// File: rtl/cmd_router.sv
// -----------------------------------------------------------------------------
// cmd_router
// Routes 32-bit host commands to one of N_TGT command targets and returns
// exactly one 32-bit response per command to the host response FIFO.
// Unknown targets (code 01) and targets that stay silent for TIMEOUT EXE
// cycles (code 02) produce {ERR_TAG, sel[7:0], code} error responses.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   cmd_data       command FIFO head (show-ahead)
//   cmd_waitreq    command FIFO empty
//   cmd_rdreq      command FIFO pop pulse
//   rsp_data       response word, updated on entry to WAIT_RSP
//   rsp_wrreq      response FIFO push pulse
//   rsp_waitreq    response FIFO full
//   tgt_cmd        latched command, broadcast to all targets
//   tgt_run        one-hot run strobe, only in EXE
//   tgt_rsp_data   target responses, target i at [32i+31:32i]
//   tgt_rsp_rdy    target response valid flags
//   busy           FSM not in IDLE
//   err_cnt        saturating count of error responses
// -----------------------------------------------------------------------------
module cmd_router #(
   parameter int          N_TGT   = 4,
   parameter int          TGT_MSB = 31,
   parameter int          TGT_LSB = 28,
   parameter int          TIMEOUT = 1023,
   parameter logic [15:0] ERR_TAG = 16'hDEAD
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [31:0]            cmd_data,
   input  logic                   cmd_waitreq,
   output logic                   cmd_rdreq,
   output logic [31:0]            rsp_data,
   output logic                   rsp_wrreq,
   input  logic                   rsp_waitreq,
   output logic [31:0]            tgt_cmd,
   output logic [N_TGT-1:0]       tgt_run,
   input  logic [32*N_TGT-1:0]    tgt_rsp_data,
   input  logic [N_TGT-1:0]       tgt_rsp_rdy,
   output logic                   busy,
   output logic [15:0]            err_cnt
);

   localparam int TW = TGT_MSB - TGT_LSB + 1;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic [2:0] {
      IDLE,
      RD_CMD,
      EXE,
      WAIT_RSP,
      WR_RSP
   } state_t;

   state_t              state, state_nx;
   logic [31:0]         cmd_reg;
   logic [TW-1:0]       sel;
   logic [CW-1:0]       tmo_cnt;
   logic [31:0]         rsp_reg;
   logic [15:0]         err_reg;

   logic                sel_ok;
   logic [7:0]          sel8;
   logic [N_TGT-1:0]    rdy_vec;
   logic                rdy_sel;
   logic [32*N_TGT-1:0] dat_vec;
   logic [31:0]         rsp_sel;
   logic                tmo_hit;
   logic                rsp_ld;
   logic [31:0]         rsp_nx;
   logic                err_ld;

   // Selected target's rdy/data extracted by shifting rather than indexing,
   // so any sel width works and out-of-range sel never indexes past the bus.
   always_comb begin
      sel_ok  = (32'(sel) < 32'(N_TGT));
      sel8    = 8'(sel);
      rdy_vec = tgt_rsp_rdy >> sel;
      rdy_sel = rdy_vec[0];
      dat_vec = tgt_rsp_data >> {sel, 5'd0};
      rsp_sel = dat_vec[31:0];
      tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TO_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      cmd_rdreq = 1'b0;
      rsp_wrreq = 1'b0;
      tgt_run   = '0;
      rsp_ld    = 1'b0;
      rsp_nx    = rsp_reg;
      err_ld    = 1'b0;
      case (state)
         IDLE: begin
            if (!cmd_waitreq) state_nx = RD_CMD;
         end
         RD_CMD: begin
            cmd_rdreq = 1'b1;
            state_nx  = EXE;
         end
         EXE: begin
            if (!sel_ok) begin
               rsp_ld   = 1'b1;
               rsp_nx   = {ERR_TAG, sel8, 8'h01};
               err_ld   = 1'b1;
               state_nx = WAIT_RSP;
            end else begin
               tgt_run = N_TGT'(1) << sel;
               // rdy has priority over a coincident timeout
               if (rdy_sel) begin
                  rsp_ld   = 1'b1;
                  rsp_nx   = rsp_sel;
                  state_nx = WAIT_RSP;
               end else if (tmo_hit) begin
                  rsp_ld   = 1'b1;
                  rsp_nx   = {ERR_TAG, sel8, 8'h02};
                  err_ld   = 1'b1;
                  state_nx = WAIT_RSP;
               end
            end
         end
         WAIT_RSP: begin
            if (!rsp_waitreq) state_nx = WR_RSP;
         end
         WR_RSP: begin
            rsp_wrreq = 1'b1;
            state_nx  = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_reg <= '0;
         sel     <= '0;
         tmo_cnt <= '0;
         rsp_reg <= '0;
         err_reg <= '0;
      end else begin
         if (state == RD_CMD) begin
            cmd_reg <= cmd_data;
            sel     <= cmd_data[TGT_MSB:TGT_LSB];
            tmo_cnt <= '0;
         end else if (state == EXE && !rsp_ld) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
         if (rsp_ld) rsp_reg <= rsp_nx;
         if (err_ld && err_reg != '1) err_reg <= err_reg + 1'b1;
      end
   end

   assign tgt_cmd  = cmd_reg;
   assign rsp_data = rsp_reg;
   assign err_cnt  = err_reg;
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_cmd_router.sv
// -----------------------------------------------------------------------------
// tb_cmd_router
// Directed bench for cmd_router (N_TGT=4, target field [31:28], TIMEOUT=8).
// Expected responses are queued when a command is issued and compared when
// the router pushes to the response FIFO.
// -----------------------------------------------------------------------------
module tb_cmd_router;

   localparam int N  = 4;
   localparam int TO = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [31:0]     cmd_data;
   logic            cmd_waitreq;
   logic            cmd_rdreq;
   logic [31:0]     rsp_data;
   logic            rsp_wrreq;
   logic            rsp_waitreq;
   logic [31:0]     tgt_cmd;
   logic [N-1:0]    tgt_run;
   logic [32*N-1:0] tgt_rsp_data;
   logic [N-1:0]    tgt_rsp_rdy;
   logic            busy;
   logic [15:0]     err_cnt;

   int              n_assert = 0;
   int              n_fail   = 0;
   int              n_push   = 0;
   int              exp_push = 0;
   int              exp_err  = 0;
   logic [31:0]     exp_q[$];

   always #5 clk = ~clk;

   cmd_router #(
      .N_TGT   (N),
      .TGT_MSB (31),
      .TGT_LSB (28),
      .TIMEOUT (TO),
      .ERR_TAG (16'hDEAD)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_data     (cmd_data),
      .cmd_waitreq  (cmd_waitreq),
      .cmd_rdreq    (cmd_rdreq),
      .rsp_data     (rsp_data),
      .rsp_wrreq    (rsp_wrreq),
      .rsp_waitreq  (rsp_waitreq),
      .tgt_cmd      (tgt_cmd),
      .tgt_run      (tgt_run),
      .tgt_rsp_data (tgt_rsp_data),
      .tgt_rsp_rdy  (tgt_rsp_rdy),
      .busy         (busy),
      .err_cnt      (err_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Response scoreboard: every push is compared against the oldest expectation.
   always @(negedge clk) begin
      if (rsp_wrreq === 1'b1) begin
         n_push++;
         if (exp_q.size() != 0) chk("rsp_push_data", rsp_data, exp_q.pop_front());
      end
   end

   // Issue one command from IDLE (called at a negedge) and follow it cycle by
   // cycle through RD_CMD, n_exe EXE cycles, WAIT_RSP (bp cycles of full FIFO),
   // WR_RSP and back to IDLE.
   task automatic do_cmd(input logic [31:0] cmd, input int rdy_at, input logic [31:0] rdata,
                         input int n_exe, input int bp, input bit more, input bit spur,
                         input logic [31:0] exp_rsp, input bit is_err);
      int         s;
      int         err0;
      int         nw;
      logic [3:0] mask;
      logic [3:0] base;
      s    = int'(cmd[31:28]);
      err0 = exp_err;
      mask = (s < N) ? 4'(1 << s) : 4'b0000;
      base = spur ? ~mask : 4'b0000;
      for (int i = 0; i < N; i++)
         tgt_rsp_data[32*i +: 32] = (i == s) ? rdata : (32'hBAD0_0000 | 32'(i));
      chk("idle_busy_pre", 32'(busy), 32'd0);
      exp_q.push_back(exp_rsp);
      exp_push++;
      if (is_err) exp_err++;
      cmd_data    = cmd;
      cmd_waitreq = 1'b0;
      rsp_waitreq = 1'b0;
      tgt_rsp_rdy = spur ? 4'hF : 4'h0;

      @(negedge clk);
      chk("rd_cmd_rdreq", 32'(cmd_rdreq), 32'd1);
      chk("rd_cmd_run", 32'(tgt_run), 32'd0);
      chk("rd_cmd_busy", 32'(busy), 32'd1);
      if (!more) cmd_waitreq = 1'b1;

      for (int k = 1; k <= n_exe; k++) begin
         @(negedge clk);
         chk("exe_run", 32'(tgt_run), 32'(mask));
         chk("exe_rdreq", 32'(cmd_rdreq), 32'd0);
         chk("exe_wrreq", 32'(rsp_wrreq), 32'd0);
         chk("exe_err_cnt", 32'(err_cnt), 32'(err0));
         if (k == 1) chk("exe_tgt_cmd", tgt_cmd, cmd);
         if (k == n_exe && bp > 0) rsp_waitreq = 1'b1;
         tgt_rsp_rdy = base | ((k == rdy_at) ? mask : 4'b0000);
      end

      nw = (bp > 0) ? bp : 1;
      for (int j = 0; j < nw; j++) begin
         @(negedge clk);
         chk("wait_run", 32'(tgt_run), 32'd0);
         chk("wait_wrreq", 32'(rsp_wrreq), 32'd0);
         chk("wait_rdreq", 32'(cmd_rdreq), 32'd0);
         chk("wait_busy", 32'(busy), 32'd1);
         chk("wait_rsp_data", rsp_data, exp_rsp);
         if (j == 0) begin
            chk("wait_err_cnt", 32'(err_cnt), 32'(exp_err));
            tgt_rsp_rdy = spur ? 4'hF : 4'h0;
         end
         if (j == nw - 1) rsp_waitreq = 1'b0;
      end

      @(negedge clk);
      chk("wr_wrreq", 32'(rsp_wrreq), 32'd1);
      chk("wr_rdreq", 32'(cmd_rdreq), 32'd0);
      chk("wr_rsp_data", rsp_data, exp_rsp);
      tgt_rsp_rdy = 4'h0;

      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_wrreq", 32'(rsp_wrreq), 32'd0);
      chk("idle_tgt_cmd_hold", tgt_cmd, cmd);
      chk("idle_err_cnt", 32'(err_cnt), 32'(exp_err));
   endtask

   task automatic chk_reset(input string pfx);
      chk({pfx, "_rdreq"}, 32'(cmd_rdreq), 32'd0);
      chk({pfx, "_wrreq"}, 32'(rsp_wrreq), 32'd0);
      chk({pfx, "_run"}, 32'(tgt_run), 32'd0);
      chk({pfx, "_busy"}, 32'(busy), 32'd0);
      chk({pfx, "_tgt_cmd"}, tgt_cmd, 32'd0);
      chk({pfx, "_rsp_data"}, rsp_data, 32'd0);
      chk({pfx, "_err_cnt"}, 32'(err_cnt), 32'd0);
   endtask

   initial begin
      rst_n        = 1'b0;
      cmd_data     = '0;
      cmd_waitreq  = 1'b1;
      rsp_waitreq  = 1'b0;
      tgt_rsp_data = '0;
      tgt_rsp_rdy  = '0;
      repeat (2) @(negedge clk);
      chk_reset("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // single command, target 1 answers on its 3rd EXE cycle
      do_cmd(32'h1000_00AB, 3, 32'h1234_5678, 3, 0, 1'b0, 1'b0, 32'h1234_5678, 1'b0);
      // unknown target 7
      do_cmd(32'h7000_0000, 0, 32'h0, 1, 0, 1'b0, 1'b0, 32'hDEAD_0701, 1'b1);
      // silent target 0 times out after exactly TO cycles
      do_cmd(32'h0000_0000, 0, 32'h0, TO, 0, 1'b0, 1'b0, 32'hDEAD_0002, 1'b1);
      // rdy on the last allowed cycle beats the timeout
      do_cmd(32'h0000_1111, TO, 32'hCAFE_F00D, TO, 0, 1'b0, 1'b0, 32'hCAFE_F00D, 1'b0);
      // response FIFO full for 20 cycles, command FIFO stays non-empty
      do_cmd(32'h2000_0002, 1, 32'h5555_AAAA, 1, 20, 1'b1, 1'b0, 32'h5555_AAAA, 1'b0);
      // back-to-back stream with spurious rdy from other targets
      do_cmd(32'h0000_0010, 1, 32'hA0A0_0000, 1, 0, 1'b1, 1'b1, 32'hA0A0_0000, 1'b0);
      do_cmd(32'h1000_0011, 1, 32'hA1A1_1111, 1, 0, 1'b1, 1'b1, 32'hA1A1_1111, 1'b0);
      do_cmd(32'h2000_0012, 1, 32'hA2A2_2222, 1, 0, 1'b1, 1'b1, 32'hA2A2_2222, 1'b0);
      do_cmd(32'h3000_0013, 1, 32'hA3A3_3333, 1, 0, 1'b0, 1'b1, 32'hA3A3_3333, 1'b0);
      // first out-of-range target
      do_cmd(32'h4000_0000, 0, 32'h0, 1, 0, 1'b0, 1'b0, 32'hDEAD_0401, 1'b1);

      // reset during EXE aborts the command without a push
      cmd_data    = 32'h1000_0000;
      cmd_waitreq = 1'b0;
      @(negedge clk);
      chk("rst_rd_rdreq", 32'(cmd_rdreq), 32'd1);
      cmd_waitreq = 1'b1;
      @(negedge clk);
      chk("rst_exe_run", 32'(tgt_run), 32'd2);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset("mid_exe_reset");
      exp_err = 0;
      repeat (2) @(negedge clk);
      chk("rst_hold_wrreq", 32'(rsp_wrreq), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      do_cmd(32'h3000_0099, 2, 32'h1357_9BDF, 2, 0, 1'b0, 1'b0, 32'h1357_9BDF, 1'b0);

      repeat (3) @(negedge clk);
      chk("push_count", 32'(n_push), 32'(exp_push));
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/cmd_router.md
# cmd_router

Parametrised command/response router between the host command FIFO pair and N command targets (TAP, PHF and later additions). It pops one 32-bit command and latches it, then decodes the target field and runs the selected target until that target reports a response. The response is written to the response FIFO without ever dropping it. Unknown targets and unresponsive targets produce an error response, so the host always receives exactly one response per command.

## Interface
- N_TGT, 4: number of targets, 1..256.
- TGT_MSB, 31: MSB of the target field in the command word.
- TGT_LSB, 28: LSB of the target field. TW = TGT_MSB-TGT_LSB+1.
- TIMEOUT, 1023: maximum EXE cycles before a timeout error. 0 disables the timeout.
- ERR_TAG, 16'hDEAD: upper 16 bits of every error response.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_data  in  32  command FIFO head (show-ahead); valid while cmd_waitreq=0.
- cmd_waitreq  in  1  command FIFO empty.
- cmd_rdreq  out  1  command FIFO pop, one-cycle pulse.
- rsp_data  out  32  response word; stable from WAIT_RSP through WR_RSP.
- rsp_wrreq  out  1  response FIFO push, one-cycle pulse.
- rsp_waitreq  in  1  response FIFO full.
- tgt_cmd  out  32  latched command, broadcast to all targets.
- tgt_run  out  N_TGT  one-hot run strobe; only the selected bit is high, and only in EXE.
- tgt_rsp_data  in  32*N_TGT  target responses; target i occupies bits [32i+31:32i].
- tgt_rsp_rdy  in  N_TGT  target i response valid.
- busy  out  1  high when the FSM is not in IDLE.
- err_cnt  out  16  saturating count of error responses issued.

## Operation
- FSM states: IDLE, RD_CMD, EXE, WAIT_RSP, WR_RSP.
- IDLE -> RD_CMD when cmd_waitreq=0.
- RD_CMD:
  - cmd_rdreq=1.
  - cmd_data is captured into cmd_reg (drives tgt_cmd).
  - sel = cmd_data[TGT_MSB:TGT_LSB] is captured.
  - The timeout counter is cleared.
  - Next state is EXE.
- EXE, sel >= N_TGT: tgt_run stays all-zero. rsp_reg = {ERR_TAG, sel zero-extended/truncated to 8 bits, 8'h01}. Next state is WAIT_RSP.
- EXE, valid sel: tgt_run[sel]=1.
  - tgt_rsp_rdy[sel]=1: rsp_reg = tgt_rsp_data slice sel; next state is WAIT_RSP.
  - Otherwise, with TIMEOUT != 0 and counter == TIMEOUT-1: rsp_reg = {ERR_TAG, sel[7:0], 8'h02}; next state is WAIT_RSP.
  - Otherwise the counter increments.
- Rdy from non-selected targets is ignored in every state. Rdy outside EXE is ignored.
- WAIT_RSP -> WR_RSP when rsp_waitreq=0. The block holds indefinitely while the FIFO is full and never drops a response.
- WR_RSP: rsp_wrreq=1; next state is IDLE.
- err_cnt increments by 1 on each transition into WAIT_RSP that carries an error response (code 01 or 02). It saturates at 16'hFFFF.
- Counter width: $clog2(TIMEOUT+1), with a minimum of 1.

## Timing
- Reset values (asynchronous):
  - fsm=IDLE.
  - cmd_rdreq=0, rsp_wrreq=0, tgt_run=0, busy=0.
  - tgt_cmd=0, rsp_data=0, err_cnt=0.
- Minimum latency: cmd_waitreq falls at cycle 0 in IDLE.
  - Cycle 1: RD_CMD, cmd_rdreq=1.
  - Cycle 2: EXE, tgt_run=1.
  - Cycle 3: WAIT_RSP, assuming rdy arrived in cycle 2.
  - Cycle 4: WR_RSP, rsp_wrreq=1, assuming rsp_waitreq=0.
  - Cycle 5: IDLE.
- Back-to-back commands therefore take 5 cycles each.
- Timeout: EXE lasts exactly TIMEOUT cycles when no rdy arrives.
- Rdy and timeout in the same cycle: rdy wins and no error is counted.
- tgt_run[sel] drops on the edge after rdy is sampled. Targets must tolerate a one-cycle run pulse.
- tgt_cmd holds its value after the command completes, until the next RD_CMD.
- rsp_data changes only on entry to WAIT_RSP.
- Reset mid-operation aborts the command. No rsp_wrreq is issued, and the popped command is lost.

## Test plan
- Single command: cmd_data=32'h1000_00AB, target 1 returns 32'h1234_5678 on its 3rd EXE cycle.
  - Required: exactly one cmd_rdreq pulse, then tgt_run=4'b0010 for 3 cycles.
  - Required: one rsp_wrreq with rsp_data=32'h1234_5678; err_cnt=0.
- Bad target: N_TGT=4, cmd_data=32'h7000_0000.
  - Required: tgt_run never asserts.
  - Required: rsp_data=32'hDEAD_0701 written 3 cycles after RD_CMD; err_cnt=1.
- Timeout: TIMEOUT=8, target 0 is silent.
  - Required: tgt_run[0] high for exactly 8 cycles, then rsp_data=32'hDEAD_0002; err_cnt=1.
  - Repeat with rdy on the 8th cycle: the target data is written and err_cnt is unchanged.
- Backpressure: rsp_waitreq=1 for 20 cycles after rdy.
  - Required: the FSM stays in WAIT_RSP, rsp_data is stable, and there is no rsp_wrreq and no new cmd_rdreq.
  - Required: one push once rsp_waitreq=0.
- Stream and isolation: 4 back-to-back commands to targets 0..3, with spurious rdy from non-selected targets.
  - Required: the responses come out in order with the correct slices, one per 5 cycles.
  - Required: the spurious rdys have no effect.
- Reset mid-EXE: assert rst_n=0 during EXE.
  - Required: all outputs go to reset values immediately, and no rsp_wrreq is issued.
  - Required: after release, the next command is processed normally.
